spi_mem_ctrl: RTL
=================

Name: spi_mem_ctrl

Overview:
Memory-side bus slave that sits directly downstream of the CPU core. It services the core's single-outstanding byte bus (address, write data, read/write strobes, wait) by running one SPI transaction per access against an external 23LC-style serial SRAM. It stalls the core with bus_wait until the transfer completes, then returns the read data or retires the write.

Parameters:
CLK_DIV, 1, number of clk cycles per SCLK half-period (≥1).
CMD_READ, 8'h03, SPI read opcode.
CMD_WRITE, 8'h02, SPI write opcode.

Ports:
clk  input  1  system clock
rst  input  1  reset. One clock; reset is synchronous and active-high.
bus_address  input  16  byte address from the core
bus_data_write  input  8  write data from the core
bus_read  input  1  read request, held until the access completes
bus_write  input  1  write request, held until the access completes
bus_data_read  output  8  read data to the core (registered)
bus_wait  output  1  stall to the core
spi_sclk  output  1  SPI clock, mode 0
spi_cs_n  output  1  SPI chip select, active-low
spi_mosi  output  1  SPI data out
spi_miso  input  1  SPI data in

Behaviour:
- Reset values: bus_data_read=8'h00, spi_cs_n=1, spi_sclk=0, spi_mosi=0, state=IDLE, all counters 0.
- bus_wait is combinational: (bus_read|bus_write) && state!=DONE. It is high in the first cycle a request appears. It is low for exactly one cycle (DONE).
- States:
  - IDLE: if bus_write, latch {CMD_WRITE, bus_address, bus_data_write} into 32-bit shreg. Else if bus_read, latch {CMD_READ, bus_address, 8'h00}. Then go to LOAD. Write wins if both strobes are high.
  - LOAD: spi_cs_n<=0, spi_mosi<=shreg[31], bit counter=0, half counter=0. Go to SHIFT.
  - SHIFT: each bit lasts 2*CLK_DIV cycles; SCLK is low for the first half and high for the second.
    - At the low→high transition, sample spi_miso into rx shift reg.
    - At the high→low transition, shift shreg left and drive the new shreg[31] on mosi.
    - After bit 31's high half, sclk<=0 and go to END.
  - END: spi_cs_n<=1. If the access is a read, bus_data_read<=last 8 sampled bits, MSB first. Go to DONE.
  - DONE: one cycle, bus_wait=0. Go to IDLE unconditionally.
- Core contract: the core drops its strobe on the edge leaving DONE, so IDLE never re-triggers on a stale request.
- Latency: request visible in cycle 0 (IDLE) → DONE in cycle 3+64*CLK_DIV. For CLK_DIV=1 this is cycle 67.
- The address and write data are captured only in IDLE. Changes on the inputs mid-transfer are ignored.
- A strobe dropped mid-transfer does not abort the transfer; it completes and DONE passes with no effect on the core.
- bus_data_read holds its value until the next read's END. Writes never modify it.
- Address wrap: the full 16 bits are sent verbatim; 16'hFFFF is legal.
- Reset asserted in any state: next cycle spi_cs_n=1, sclk=0, state=IDLE, bus_data_read=0. The SPI transfer is aborted with no completion cycle.

Test Plan:
- Reset then idle: no strobes for 20 cycles → cs_n=1, sclk=0, bus_wait=0, bus_data_read=8'h00.
- Read, CLK_DIV=1: bus_read=1, addr 16'h1234; SPI model returns 8'hA5 → MOSI stream 03 12 34 00, 32 SCLK rising edges, bus_wait low only in cycle 67, bus_data_read=8'hA5 from cycle 67.
- Write, CLK_DIV=2: bus_write=1, addr 16'hFFFF, data 8'h3C → MOSI stream 02 FF FF 3C, SCLK period 4 clk, bus_wait low in cycle 131, bus_data_read unchanged.
- Back-to-back fetches with the CPU core as master: memory preloaded with 06 42 04 C3 00 00 (LD B,42; INC B; JP 0000) → core register B reaches 8'h43 and PC returns to 0. No duplicated SPI transaction per fetch (cs_n falls exactly once per core request).
- Both strobes high, addr 16'h0010, data 8'h99 → write opcode 02 is sent, a single transaction occurs.
- Reset mid-transfer: assert rst at SCLK edge 10 of a read → next cycle cs_n=1, sclk=0, bus_data_read=0. A subsequent read to 16'h0001 completes normally.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_ctrl
// Brief    : Byte-bus slave that services each access with a single SPI
//            transaction against a 23LC-style serial SRAM (mode 0).
// Revision : 1.0
// ============================================================================
module spi_mem_ctrl #(
    parameter int         CLK_DIV   = 1,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_data_write,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [7:0]  bus_data_read,
    output logic        bus_wait,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_END   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int            HW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic [2:0]    state;
    logic [31:0]   shreg;
    logic [7:0]    rx;
    logic [4:0]    bit_cnt;
    logic [HW-1:0] half_cnt;
    logic          is_read;

    assign bus_wait = (bus_read | bus_write) && (state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            shreg         <= 32'h0;
            rx            <= 8'h00;
            bit_cnt       <= 5'd0;
            half_cnt      <= '0;
            is_read       <= 1'b0;
            bus_data_read <= 8'h00;
            spi_sclk      <= 1'b0;
            spi_cs_n      <= 1'b1;
            spi_mosi      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Write takes priority when both strobes are raised together
                    if (bus_write) begin
                        shreg   <= {CMD_WRITE, bus_address, bus_data_write};
                        is_read <= 1'b0;
                        state   <= S_LOAD;
                    end else if (bus_read) begin
                        shreg   <= {CMD_READ, bus_address, 8'h00};
                        is_read <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    spi_cs_n <= 1'b0;
                    spi_mosi <= shreg[31];
                    bit_cnt  <= 5'd0;
                    half_cnt <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx       <= {rx[6:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                state <= S_END;
                            end else begin
                                shreg    <= {shreg[30:0], 1'b0};
                                spi_mosi <= shreg[30];
                                bit_cnt  <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                S_END: begin
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                    // Only the final 8 sampled bits carry the memory's data byte
                    if (is_read) begin
                        bus_data_read <= rx;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
